// File: rtl/seq_actfn_if.sv
// rtl/seq_actfn_if.sv - input/output handshake bundle for the sequential activation unit
interface seq_actfn_if #(
    parameter int NUM_WIDTH = 32,
    parameter int CHANNELS  = 3
);
    logic                          in_valid;
    logic                          in_ready;
    logic [1:0]                    mode;
    logic [CHANNELS*NUM_WIDTH-1:0] x_pk;
    logic                          out_valid;
    logic                          out_ready;
    logic [CHANNELS*NUM_WIDTH-1:0] res_pk;

    modport master (
        output in_valid, mode, x_pk, out_ready,
        input  in_ready, out_valid, res_pk
    );

    modport slave (
        input  in_valid, mode, x_pk, out_ready,
        output in_ready, out_valid, res_pk
    );
endinterface

// File: rtl/seq_actfn_unit.sv
// rtl/seq_actfn_unit.sv - sequential leaky ReLU / softmax / softmax-derivative / identity unit
module seq_actfn_unit #(
    parameter int NUM_WIDTH  = 32,
    parameter int FRAC_WIDTH = 16,
    parameter int CHANNELS   = 3,
    parameter int LEAK_SHIFT = 2
) (
    input logic         clk,
    input logic         rst_n,
    seq_actfn_if.slave  bus
);
    localparam int IW = $clog2(CHANNELS);
    localparam int SW = NUM_WIDTH + $clog2(CHANNELS);
    localparam int PW = $clog2(SW);
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
    localparam logic [NUM_WIDTH-1:0] ONE =
        {{(NUM_WIDTH-FRAC_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, ELEM, MAX, EXP, INV, NORM, DIFF, DONE} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [1:0]             mode_r;
    logic [NUM_WIDTH-1:0]   x_mem   [CHANNELS];
    logic [NUM_WIDTH-1:0]   e_mem   [CHANNELS];
    logic [NUM_WIDTH-1:0]   res_mem [CHANNELS];
    logic [NUM_WIDTH-1:0]   m;
    logic [SW-1:0]          s_acc;
    logic [NUM_WIDTH-1:0]   inv;
    logic                   in_ready_r;
    logic                   out_valid_r;

    logic [NUM_WIDTH-1:0]        cur_x, cur_e, leaky, e_calc, inv_calc, mul_a, mul_b, mul_res;
    logic signed [NUM_WIDTH-1:0] xs, ms, xs_shift;
    logic signed [NUM_WIDTH:0]   d, i_part;
    logic [NUM_WIDTH:0]          neg_i;
    logic [PW-1:0]               lead, inv_sh;
    logic [SW-1:0]               mnt, three, inv_full;
    logic [2*NUM_WIDTH-1:0]      prod;
    logic [CHANNELS*NUM_WIDTH-1:0] res_flat;

    // Datapath for the element at idx: leaky shift, piecewise exp, reciprocal seed and the shared multiplier.
    always_comb begin
        cur_x    = x_mem[idx];
        cur_e    = e_mem[idx];
        xs       = cur_x;
        ms       = m;
        xs_shift = xs >>> LEAK_SHIFT;
        leaky    = xs[NUM_WIDTH-1] ? NUM_WIDTH'(xs_shift) : cur_x;

        // d <= 0 because m is the max; split into integer part (shift) and fraction (mantissa).
        d      = {xs[NUM_WIDTH-1], xs} - {ms[NUM_WIDTH-1], ms};
        i_part = d >>> FRAC_WIDTH;
        neg_i  = -i_part;
        if (neg_i > (NUM_WIDTH+1)'(FRAC_WIDTH))
            e_calc = '0;
        else
            e_calc = NUM_WIDTH'({1'b1, d[FRAC_WIDTH-1:0]}) >> neg_i;

        // Reciprocal of S: normalise to [1,2), linear estimate 1.5 - mnt/2, scale back.
        lead = '0;
        for (int i = 0; i < SW; i++)
            if (s_acc[i]) lead = PW'(i);
        inv_sh   = lead - PW'(FRAC_WIDTH);
        mnt      = s_acc >> inv_sh;
        three    = SW'(3) << FRAC_WIDTH;
        inv_full = ((three - mnt) >> 1) >> inv_sh;
        inv_calc = NUM_WIDTH'(inv_full);

        mul_a   = cur_e;
        mul_b   = (state == DIFF) ? (ONE - cur_e) : inv;
        prod    = {{NUM_WIDTH{1'b0}}, mul_a} * {{NUM_WIDTH{1'b0}}, mul_b};
        mul_res = NUM_WIDTH'(prod >> FRAC_WIDTH);
    end

    // Pack per-channel results into the output vector.
    always_comb begin
        res_flat = '0;
        for (int i = 0; i < CHANNELS; i++)
            res_flat[i*NUM_WIDTH +: NUM_WIDTH] = res_mem[i];
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.res_pk    = res_flat;

    // Control FSM and all per-phase state; one element processed per cycle in each vector phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            mode_r      <= '0;
            m           <= '0;
            s_acc       <= '0;
            inv         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                x_mem[i]   <= '0;
                e_mem[i]   <= '0;
                res_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < CHANNELS; i++)
                            x_mem[i] <= bus.x_pk[i*NUM_WIDTH +: NUM_WIDTH];
                        mode_r     <= bus.mode;
                        idx        <= '0;
                        s_acc      <= '0;
                        in_ready_r <= 1'b0;
                        state      <= (bus.mode == 2'd1 || bus.mode == 2'd2) ? MAX : ELEM;
                    end
                end
                ELEM: begin
                    res_mem[idx] <= (mode_r == 2'd0) ? leaky : cur_x;
                    idx          <= idx + 1'b1;
                    if (idx == LAST) state <= DONE;
                end
                MAX: begin
                    if (idx == '0 || xs > ms) m <= cur_x;
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) state <= EXP;
                end
                EXP: begin
                    e_mem[idx] <= e_calc;
                    s_acc      <= s_acc + SW'(e_calc);
                    idx        <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) state <= INV;
                end
                INV: begin
                    inv   <= inv_calc;
                    state <= NORM;
                end
                NORM: begin
                    e_mem[idx]   <= mul_res;
                    res_mem[idx] <= mul_res;
                    idx          <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) state <= (mode_r == 2'd2) ? DIFF : DONE;
                end
                DIFF: begin
                    res_mem[idx] <= mul_res;
                    idx          <= idx + 1'b1;
                    if (idx == LAST) state <= DONE;
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_actfn_unit.sv
// tb/tb_seq_actfn_unit.sv - directed and randomized bench for seq_actfn_unit
module tb_seq_actfn_unit;
    localparam int NW = 32;
    localparam int C  = 3;
    localparam int W  = NW * C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_actfn_if #(.NUM_WIDTH(NW), .CHANNELS(C)) bus();

    seq_actfn_unit #(.NUM_WIDTH(NW), .FRAC_WIDTH(16), .CHANNELS(C), .LEAK_SHIFT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: real-number-style arithmetic on 64-bit integers, straight from the activation rules.
    function automatic logic [W-1:0] model(input logic [1:0] md, input logic [W-1:0] xp);
        longint x[C], e[C], r[C];
        longint mx, s_sum, d, f, ip, mnt, inv, s;
        logic signed [NW-1:0] t;
        logic [W-1:0] out;
        int p;
        for (int i = 0; i < C; i++) begin
            t = xp[i*NW +: NW];
            x[i] = t;
        end
        if (md == 2'd0 || md == 2'd3) begin
            for (int i = 0; i < C; i++)
                r[i] = (md == 2'd3 || x[i] >= 0) ? x[i] : (x[i] >>> 2);
        end else begin
            mx = x[0];
            for (int i = 1; i < C; i++) if (x[i] > mx) mx = x[i];
            s_sum = 0;
            for (int i = 0; i < C; i++) begin
                d  = x[i] - mx;
                f  = d & 64'hFFFF;
                ip = (d - f) / 65536;
                e[i] = (-ip > 16) ? 0 : ((65536 + f) >> (-ip));
                s_sum += e[i];
            end
            p = 0;
            for (int b = 0; b < 48; b++) if (((s_sum >> b) & 1) != 0) p = b;
            mnt = s_sum >> (p - 16);
            inv = ((3 * 65536 - mnt) / 2) >> (p - 16);
            for (int i = 0; i < C; i++) begin
                s = (e[i] * inv) >> 16;
                r[i] = (md == 2'd2) ? ((s * (65536 - s)) >> 16) : s;
            end
        end
        for (int i = 0; i < C; i++) out[i*NW +: NW] = r[i][NW-1:0];
        return out;
    endfunction

    function automatic int exp_lat(input logic [1:0] md);
        if (md == 2'd0 || md == 2'd3) return C + 1;
        if (md == 2'd1) return 3 * C + 2;
        return 4 * C + 2;
    endfunction

    task automatic start(input logic [1:0] md, input logic [W-1:0] xp);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", W'(bus.in_ready), W'(1));
        bus.in_valid = 1'b1;
        bus.mode     = md;
        bus.x_pk     = xp;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.mode     = 2'($urandom);
        bus.x_pk     = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_out_valid_drop"}, W'(bus.out_valid), W'(0));
        check({tag, "_in_ready_rise"}, W'(bus.in_ready), W'(1));
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] md, input logic [W-1:0] xp,
                       input logic [W-1:0] exp_res);
        int lat;
        start(md, xp);
        wait_out(lat);
        check({tag, "_latency"}, W'(lat), W'(exp_lat(md)));
        check({tag, "_res"}, bus.res_pk, exp_res);
        release_out(tag);
    endtask

    logic [W-1:0] xv, ev;
    logic [1:0]   md;
    int           lat;

    initial begin
        bus.in_valid  = 1'b0;
        bus.mode      = 2'd0;
        bus.x_pk      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_res", bus.res_pk, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        run("leaky", 2'd0, {32'hFFFC0000, 32'hFFFFFFFD, 32'h00000003},
            {32'hFFFF0000, 32'hFFFFFFFF, 32'h00000003});
        run("sm_zero", 2'd1, '0, {32'h6000, 32'h6000, 32'h6000});
        run("sm_one", 2'd1, {32'h0, 32'h0, 32'h10000}, {32'h4000, 32'h4000, 32'h8000});
        run("sm_uflow", 2'd1, {32'h0, 32'hFFEF0000, 32'h0}, {32'h8000, 32'h0, 32'h8000});
        run("dsm_zero", 2'd2, '0, {32'h3C00, 32'h3C00, 32'h3C00});
        run("ident", 2'd3, {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF},
            {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF});

        // Output held under backpressure while new requests are offered
        xv = {32'h00018000, 32'hFFFF0000, 32'h00004000};
        ev = model(2'd1, xv);
        start(2'd1, xv);
        wait_out(lat);
        check("hold_latency", W'(lat), W'(exp_lat(2'd1)));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.mode     = 2'd0;
            bus.x_pk     = {$urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("hold_out_valid", W'(bus.out_valid), W'(1));
            check("hold_in_ready", W'(bus.in_ready), W'(0));
            check("hold_res", bus.res_pk, ev);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        release_out("hold");

        // Back-to-back identical vectors
        run("b2b_a", 2'd2, xv, model(2'd2, xv));
        run("b2b_b", 2'd2, xv, model(2'd2, xv));

        // Reset in the middle of the exp phase
        start(2'd1, {32'h00030000, 32'h0, 32'hFFFE0000});
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", W'(bus.out_valid), W'(0));
        check("midrst_res", bus.res_pk, '0);
        check("midrst_in_ready", W'(bus.in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_valid", W'(bus.out_valid), W'(0));
        xv = {32'h00020000, 32'hFFFF8000, 32'h00010000};
        run("post_rst", 2'd1, xv, model(2'd1, xv));

        // Randomized vectors against the reference model
        for (int n = 0; n < 24; n++) begin
            md = 2'($urandom_range(0, 3));
            for (int i = 0; i < C; i++)
                xv[i*NW +: NW] = (n % 3 == 0) ? $urandom
                               : 32'($urandom_range(0, 32'h00100000)) - 32'h00080000;
            run($sformatf("rand%0d_m%0d", n, md), md, xv, model(md, xv));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
